wb_pci_bram: RTL and testbench

- Wishbone slave block-RAM sitting directly downstream of the PCI memory bridge; consumes its single reads and streamed writes.
- Provides a 2^ADDRESS x 32-bit word store with byte-lane writes and a registered read pipeline.
- Issues a one-cycle retry when the shared bank is busy (the second RAM port is claimed by the display engine).
- Single clock domain, the Wishbone clock.

---
 rtl/wb_pci_bram.sv | 148 ++++++++++++++
 tb/tb_wb_pci_bram.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pci_bram.sv
// ============================================================================
// Module   : wb_pci_bram
// Brief    : Wishbone slave block-RAM with byte-lane writes, a registered read
//            pipeline (RDLAT 1/2) and one-cycle retry while the bank is busy.
//            Optional address-range error response: define WB_BRAM_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_pci_bram #(
    parameter int ADDRESS = 10,
    parameter int RDLAT   = 1,
    parameter int LIMIT   = 2**ADDRESS
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    input  logic [ADDRESS-1:0] wb_adr_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [31:0]        wb_dat_i,
    output logic               wb_ack_o,
    output logic               wb_rty_o,
    output logic               wb_err_o,
    output logic [3:0]         wb_sel_o,
    output logic [31:0]        wb_dat_o,
    input  logic               busy_i,
    output logic [7:0]         retries_o
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_wack  = 3'd1;
    localparam logic [2:0] c_rpipe = 3'd2;
    localparam logic [2:0] c_rack  = 3'd3;
    localparam logic [2:0] c_retry = 3'd4;
`ifdef WB_BRAM_ERR_EN
    localparam logic [2:0] c_err   = 3'd5;
`endif

    localparam logic [ADDRESS:0] c_limit = (ADDRESS+1)'(LIMIT);

    logic [2:0]  r_state;
    logic [31:0] r_mem [0:(2**ADDRESS)-1];
    logic [31:0] r_rd_data;
    logic [3:0]  r_sel;

    logic        w_req;
    logic        w_bad;
    logic        w_wr_en;
    logic [31:0] w_rd_word;

    assign w_req = wb_cyc_i & wb_stb_i;

`ifdef WB_BRAM_ERR_EN
    assign w_bad = ({1'b0, wb_adr_i} >= c_limit);
    logic w_unused;
    assign w_unused = &{1'b0, wb_cti_i, wb_bte_i};
`else
    assign w_bad = 1'b0;
    logic w_unused;
    assign w_unused = &{1'b0, wb_cti_i, wb_bte_i, c_limit};
`endif

    assign w_wr_en   = (r_state == c_idle) & w_req & wb_we_i & ~busy_i & ~w_bad;
    assign w_rd_word = r_mem[wb_adr_i];

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge wb_clk_i) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel_i[i]) begin
                    r_mem[wb_adr_i][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
        end
    end

    // Response pulses are registered on entry to WACK/RACK/RETRY/ERR; those
    // states only exist to clear the pulse and return to IDLE.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= c_idle;
            wb_ack_o  <= 1'b0;
            wb_rty_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_sel_o  <= 4'b0000;
            wb_dat_o  <= 32'h0;
            retries_o <= 8'h00;
            r_rd_data <= 32'h0;
            r_sel     <= 4'b0000;
        end else begin
            wb_ack_o <= 1'b0;
            wb_rty_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_req) begin
`ifdef WB_BRAM_ERR_EN
                        if (w_bad) begin
                            wb_err_o <= 1'b1;
                            r_state  <= c_err;
                        end else
`endif
                        if (busy_i) begin
                            wb_rty_o <= 1'b1;
                            if (retries_o != 8'hFF) begin
                                retries_o <= retries_o + 8'd1;
                            end
                            r_state <= c_retry;
                        end else if (wb_we_i) begin
                            wb_ack_o <= 1'b1;
                            r_state  <= c_wack;
                        end else if (RDLAT == 1) begin
                            wb_dat_o <= w_rd_word;
                            wb_sel_o <= wb_sel_i;
                            wb_ack_o <= 1'b1;
                            r_state  <= c_rack;
                        end else begin
                            r_rd_data <= w_rd_word;
                            r_sel     <= wb_sel_i;
                            r_state   <= c_rpipe;
                        end
                    end
                end
                c_rpipe: begin
                    // An abandoned cycle leaves the previous read data visible.
                    if (wb_cyc_i) begin
                        wb_dat_o <= r_rd_data;
                        wb_sel_o <= r_sel;
                        wb_ack_o <= 1'b1;
                        r_state  <= c_rack;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_pci_bram.sv
// ============================================================================
// Module   : tb_wb_pci_bram
// Brief    : Directed self-checking bench for wb_pci_bram (RDLAT=1 and RDLAT=2
//            instances sharing one bus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_pci_bram;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, busy;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [9:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;

    logic        ack, rty, err;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [7:0]  retries;

    logic        ack2, rty2, err2;
    logic [3:0]  sel_o2;
    logic [31:0] dat_o2;
    logic [7:0]  retries2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_pci_bram #(.ADDRESS(10), .RDLAT(1), .LIMIT(512)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_ack_o(ack), .wb_rty_o(rty),
        .wb_err_o(err), .wb_sel_o(sel_o), .wb_dat_o(dat_o), .busy_i(busy),
        .retries_o(retries)
    );

    wb_pci_bram #(.ADDRESS(10), .RDLAT(2)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_ack_o(ack2), .wb_rty_o(rty2),
        .wb_err_o(err2), .wb_sel_o(sel_o2), .wb_dat_o(dat_o2), .busy_i(busy),
        .retries_o(retries2)
    );

    // Bus drivers: one idle cycle first, then hold the request until ack.
    task automatic wb_write(input logic [9:0] a, input logic [3:0] s,
                            input logic [31:0] d, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; dat_i = d;
        lat = -1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = n;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input bit use2, input logic [9:0] a, input logic [3:0] s,
                           output logic [31:0] d, output logic [3:0] so, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = s;
        lat = -1; d = 32'h0; so = 4'h0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (use2 ? ack2 : ack) begin
                lat = n;
                d   = use2 ? dat_o2 : dat_o;
                so  = use2 ? sel_o2 : sel_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack, rty, err, sel_o, dat_o, retries} !== 47'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {ack, rty, err, sel_o, dat_o, retries});
        end
        checks++;
        if ({ack2, rty2, err2, sel_o2, dat_o2, retries2} !== 47'h0) begin
            errors++;
            $display("FAIL reset_outputs2 got %h required 0", {ack2, rty2, err2, sel_o2, dat_o2, retries2});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] d;
        logic [3:0]  so;
        wb_write(10'h005, 4'b1111, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL write_latency got %0d required 1", lat);
        end
        wb_read(1'b0, 10'h005, 4'b1111, d, so, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL read_latency got %0d required 1", lat);
        end
        checks++;
        if (d !== 32'hDEADBEEF || so !== 4'b1111) begin
            errors++;
            $display("FAIL read_data got %h/%b required deadbeef/1111", d, so);
        end
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_single_cycle got %b required 0", ack);
        end
    endtask

    task automatic test_byte_lanes();
        int lat;
        logic [31:0] d;
        logic [3:0]  so;
        wb_write(10'h3FF, 4'b1111, 32'h11223344, lat);
        wb_write(10'h3FF, 4'b0101, 32'hAABBCCDD, lat);
        wb_read(1'b0, 10'h3FF, 4'b1111, d, so, lat);
        checks++;
        if (d !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_lanes got %h required 11bb33dd", d);
        end
        wb_write(10'h3FF, 4'b0000, 32'hFFFFFFFF, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL sel0_ack got latency %0d required 1", lat);
        end
        wb_read(1'b0, 10'h3FF, 4'b1111, d, so, lat);
        checks++;
        if (d !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL sel0_unchanged got %h required 11bb33dd", d);
        end
    endtask

    task automatic test_retry();
        int lat;
        logic [31:0] d;
        logic [3:0]  so;
        wb_write(10'h010, 4'b1111, 32'h01010101, lat);
        @(posedge clk); #1;
        busy = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 10'h010; sel = 4'b1111; dat_i = 32'h5A5A5A5A;
        @(posedge clk); #1;
        checks++;
        if (rty !== 1'b1 || ack !== 1'b0 || retries !== 8'd1) begin
            errors++;
            $display("FAIL retry_pulse got rty=%b ack=%b cnt=%0d required 1/0/1", rty, ack, retries);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rty !== 1'b0) begin
            errors++;
            $display("FAIL retry_single_cycle got %b required 0", rty);
        end
        busy = 1'b0;
        wb_read(1'b0, 10'h010, 4'b1111, d, so, lat);
        checks++;
        if (d !== 32'h01010101) begin
            errors++;
            $display("FAIL retry_no_write got %h required 01010101", d);
        end
        @(posedge clk); #1;
        busy = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checks++;
        if (retries !== 8'd255) begin
            errors++;
            $display("FAIL retry_saturate got %0d required 255", retries);
        end
        @(posedge clk); #1;
        busy = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int prev = 0;
        int badgap = 0;
        int extra = 0;
        int lat;
        logic [31:0] d;
        logic [3:0]  so;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b1111; adr = 10'h020; dat_i = 32'd1;
        for (int n = 1; n <= 24 && k < 4; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                if (k > 0 && (n - prev) != 2) badgap++;
                prev = n;
                k++;
                if (k < 4) begin
                    adr   = 10'h020 + 10'(k);
                    dat_i = 32'(k + 1);
                end
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (ack) extra++;
        end
        checks++;
        if (k !== 4 || badgap !== 0 || extra !== 0) begin
            errors++;
            $display("FAIL burst_acks got acks=%0d badgaps=%0d extra=%0d required 4/0/0", k, badgap, extra);
        end
        for (int i = 0; i < 4; i++) begin
            wb_read(1'b0, 10'h020 + 10'(i), 4'b1111, d, so, lat);
            checks++;
            if (d !== 32'(i + 1)) begin
                errors++;
                $display("FAIL burst_readback[%0d] got %h required %h", i, d, 32'(i + 1));
            end
        end
    endtask

    task automatic test_rdlat2_abort();
        int lat;
        int acks = 0;
        logic [31:0] d;
        logic [3:0]  so;
        wb_read(1'b1, 10'h005, 4'b1111, d, so, lat);
        checks++;
        if (lat !== 2 || d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdlat2_read got lat=%0d data=%h required 2/deadbeef", lat, d);
        end
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'h3FF; sel = 4'b0011;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ack2) acks++;
        end
        checks++;
        if (acks !== 0 || dat_o2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdlat2_abort got acks=%0d data=%h required 0/deadbeef", acks, dat_o2);
        end
        wb_read(1'b1, 10'h3FF, 4'b0011, d, so, lat);
        checks++;
        if (lat !== 2 || d !== 32'h11BB33DD || so !== 4'b0011) begin
            errors++;
            $display("FAIL rdlat2_after_abort got lat=%0d data=%h sel=%b required 2/11bb33dd/0011", lat, d, so);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'h005; sel = 4'b1111;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1 || dat_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pre_reset_read got ack=%b data=%h required 1/deadbeef", ack, dat_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ack, rty, err, sel_o, dat_o, retries} !== 47'h0) begin
            errors++;
            $display("FAIL async_reset got %h required 0", {ack, rty, err, sel_o, dat_o, retries});
        end
        checks++;
        if ({ack2, rty2, err2, sel_o2, dat_o2, retries2} !== 47'h0) begin
            errors++;
            $display("FAIL async_reset2 got %h required 0", {ack2, rty2, err2, sel_o2, dat_o2, retries2});
        end
        #1 rst = 1'b0;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_addr_limit();
`ifdef WB_BRAM_ERR_EN
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'h200; sel = 4'b1111;
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL err_response got err=%b ack=%b required 1/0", err, ack);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_single_cycle got %b required 0", err);
        end
        busy = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || rty !== 1'b0 || retries !== 8'd0) begin
            errors++;
            $display("FAIL err_over_busy got err=%b rty=%b cnt=%0d required 1/0/0", err, rty, retries);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        busy = 1'b0;
`else
        int lat;
        logic [31:0] d;
        logic [3:0]  so;
        wb_write(10'h200, 4'b1111, 32'h12345678, lat);
        wb_read(1'b0, 10'h200, 4'b1111, d, so, lat);
        checks++;
        if (lat !== 1 || d !== 32'h12345678 || err !== 1'b0) begin
            errors++;
            $display("FAIL no_limit_read got lat=%0d data=%h err=%b required 1/12345678/0", lat, d, err);
        end
`endif
    endtask

    initial begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; busy = 1'b0;
        cti = 3'b000; bte = 2'b00; adr = 10'h0; sel = 4'h0; dat_i = 32'h0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_retry();
        test_back_to_back();
        test_rdlat2_abort();
        test_async_reset();
        test_addr_limit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
